div_sequencer: RTL

- Multi-cycle controller and datapath sequencer for 32-bit restoring division in the CPU execute stage.
- Accepts one operand pair through a valid/ready handshake and runs one shift/subtract/restore step per clock.
- Applies signed pre- and post-correction and special cases.
- Presents {quotient, remainder} as a 64-bit Z to the HI/LO write-back path through a valid/ready handshake.

---
 rtl/div_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: sequencer for multi-cycle 32-bit restoring division in the execute stage.
//
// An operand pair is accepted through a valid/ready handshake. The sequencer then
// produces one quotient bit per clock using shift/subtract/restore. Signed operands are
// converted to magnitudes before the loop and the signs are re-applied afterwards.
// The result Z = {quotient, remainder} goes to the HI/LO write-back path through a
// second valid/ready handshake.
//
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   start_valid/start_ready   operand handshake (ready only in IDLE)
//   is_signed, dividend,
//   divisor                   operands, sampled at accept
//   busy                      any state other than IDLE
//   result_valid/result_ready result handshake (valid only in DONE)
//   Z                         {quotient, remainder}, 2*WIDTH bits
//   div_by_zero               the current result came from a zero divisor
//   flush                     only when DIV_SEQ_FLUSH_EN is defined: synchronous kill
//
// Optional feature macro: DIV_SEQ_FLUSH_EN. It adds the flush input.
//
// Latency, counted in edges after the accept edge:
//   - A normal divide spends 1 PREP edge, WIDTH ITER edges and 1 FIXUP edge,
//     so DONE is reached at edge WIDTH+2.
//   - A zero divisor goes PREP -> FIXUP -> DONE, so DONE is reached at edge 2.

module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
`ifdef DIV_SEQ_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               start_valid,
  output logic               start_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [2*WIDTH-1:0] Z,
  output logic               div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PREP  = 3'd1;
  localparam logic [2:0] ST_ITER  = 3'd2;
  localparam logic [2:0] ST_FIXUP = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]         state_q,       state_d;
  logic [WIDTH-1:0]   dividend_q,    dividend_d;
  logic [WIDTH-1:0]   divisor_q,     divisor_d;
  logic               is_signed_q,   is_signed_d;
  logic [WIDTH-1:0]   a_q,           a_d;        // magnitude dividend, becomes quotient
  logic [WIDTH-1:0]   b_q,           b_d;        // magnitude divisor
  logic [WIDTH:0]     p_q,           p_d;        // partial remainder
  logic [CW-1:0]      count_q,       count_d;
  logic               neg_quo_q,     neg_quo_d;
  logic               neg_rem_q,     neg_rem_d;
  logic [2*WIDTH-1:0] z_q,           z_d;
  logic               dbz_q,         dbz_d;
  logic               start_ready_q, start_ready_d;
  logic               busy_q,        busy_d;
  logic               rvalid_q,      rvalid_d;

  logic               flush_s;
  logic [WIDTH+1:0]   shifted_s;
  logic [WIDTH+1:0]   trial_s;

`ifdef DIV_SEQ_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // One restoring step: shift {P, A} left and trial-subtract B from the shifted P.
  // The extra top bit of trial_s is the borrow, i.e. the sign of T.
  assign shifted_s = {p_q, a_q[WIDTH-1]};
  assign trial_s   = shifted_s - {2'b00, b_q};

  // Next-state and datapath load logic.
  // Flush wins over every other action and leaves the result registers untouched.
  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    is_signed_d = is_signed_q;
    a_d         = a_q;
    b_d         = b_q;
    p_d         = p_q;
    count_d     = count_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    z_d         = z_q;
    dbz_d       = dbz_q;

    if (flush_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_valid) begin
            dividend_d  = dividend;
            divisor_d   = divisor;
            is_signed_d = is_signed;
            state_d     = ST_PREP;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_PREP: begin
          if (divisor_q == {WIDTH{1'b0}}) begin
            // Pre-load A/P so that FIXUP (both signs clear) emits {all ones, dividend}.
            a_d       = {WIDTH{1'b1}};
            p_d       = {1'b0, dividend_q};
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            dbz_d     = 1'b1;
            state_d   = ST_FIXUP;
          end else begin
            // Negating the most-negative value gives 2^(W-1), which is correct when read unsigned.
            a_d       = (is_signed_q && dividend_q[WIDTH-1]) ? -dividend_q : dividend_q;
            b_d       = (is_signed_q && divisor_q[WIDTH-1])  ? -divisor_q  : divisor_q;
            neg_quo_d = is_signed_q & (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
            neg_rem_d = is_signed_q & dividend_q[WIDTH-1];
            p_d       = {(WIDTH+1){1'b0}};
            count_d   = {CW{1'b0}};
            dbz_d     = 1'b0;
            state_d   = ST_ITER;
          end
        end

        ST_ITER: begin
          if (trial_s[WIDTH+1]) begin
            p_d = shifted_s[WIDTH:0];
            a_d = {a_q[WIDTH-2:0], 1'b0};
          end else begin
            p_d = trial_s[WIDTH:0];
            a_d = {a_q[WIDTH-2:0], 1'b1};
          end
          if (count_q == CW'(WIDTH - 1)) begin
            state_d = ST_FIXUP;
          end else begin
            count_d = count_q + CW'(1);
            state_d = ST_ITER;
          end
        end

        ST_FIXUP: begin
          z_d = {(neg_quo_q ? -a_q : a_q),
                 (neg_rem_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0])};
          state_d = ST_DONE;
        end

        ST_DONE: begin
          if (result_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and status outputs are registered by decoding the next state.
  always_comb begin
    start_ready_d = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    rvalid_d      = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      dividend_q    <= {WIDTH{1'b0}};
      divisor_q     <= {WIDTH{1'b0}};
      is_signed_q   <= 1'b0;
      a_q           <= {WIDTH{1'b0}};
      b_q           <= {WIDTH{1'b0}};
      p_q           <= {(WIDTH+1){1'b0}};
      count_q       <= {CW{1'b0}};
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      z_q           <= {(2*WIDTH){1'b0}};
      dbz_q         <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      rvalid_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      dividend_q    <= dividend_d;
      divisor_q     <= divisor_d;
      is_signed_q   <= is_signed_d;
      a_q           <= a_d;
      b_q           <= b_d;
      p_q           <= p_d;
      count_q       <= count_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      z_q           <= z_d;
      dbz_q         <= dbz_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
      rvalid_q      <= rvalid_d;
    end
  end

  assign start_ready  = start_ready_q;
  assign busy         = busy_q;
  assign result_valid = rvalid_q;
  assign Z            = z_q;
  assign div_by_zero  = dbz_q;

endmodule
